delay_seq_checker: RTL
======================

DELAY_SEQ_CHECKER -- requirements
Module: delay_seq_checker

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent checker lanes (1..16).
REQ-002 Parameter MIN_DLY, default 2: earliest delay, in cycles, at which b may satisfy an attempt (1..MAX_DLY).
REQ-003 Parameter MAX_DLY, default 2: latest delay, in cycles, at which b may satisfy an attempt (MIN_DLY..16).
REQ-004 Parameter CNT_W, default 8: width of each per-lane pass and fail counter.
REQ-005 clk  input  1: single clock; all sampling is on the posedge.
REQ-006 rst_n  input  1: reset, asynchronous and active-low.
REQ-007 en  input  CHANNELS: per-lane gate on launching new attempts.
REQ-008 a  input  CHANNELS: per-lane antecedent.
REQ-009 b  input  CHANNELS: per-lane consequent.
REQ-010 clr  input  1: synchronous clear of counters and sticky flags.
REQ-011 pass_pulse  output  CHANNELS: one-cycle pulse when at least one attempt passes.
REQ-012 fail_pulse  output  CHANNELS: one-cycle pulse when at least one attempt fails.
REQ-013 pass_cnt  output  CHANNELS*CNT_W: per-lane saturating pass count; lane i occupies bits [i*CNT_W +: CNT_W].
REQ-014 fail_cnt  output  CHANNELS*CNT_W: per-lane saturating fail count, packed the same way as pass_cnt.
REQ-015 err_sticky  output  CHANNELS: set on the first fail; held until clr or reset.
REQ-016 busy  output  CHANNELS: high while the lane has any unresolved attempt.

Function
REQ-017 Launch: an attempt starts at edge E0 when a[i] & en[i] is sampled high. Overlapping attempts are allowed, one per cycle, each tracked independently.
REQ-018 Pending tracking: each lane keeps a MAX_DLY-deep age vector. Bit k set means an attempt launched k edges ago is still unresolved.
REQ-019 Pass: at edge E0+k, with MIN_DLY ≤ k ≤ MAX_DLY and b[i]=1, every pending attempt whose age is in the window passes and is retired.
REQ-020 Fail: an attempt that reaches age MAX_DLY with b[i]=0 fails and is retired.
REQ-021 Early b: b at an age below MIN_DLY has no effect on that attempt.
REQ-022 Latency: pass_pulse and fail_pulse are registered, and are high during the cycle immediately after the resolving edge.
REQ-023 Simultaneous pass and fail: a lane may assert pass_pulse and fail_pulse in the same cycle.
REQ-024 Counter increment: each counter increases by the number of attempts resolved at that edge (0..MAX_DLY-MIN_DLY+1).
REQ-025 Counter saturation: counters saturate at 2^CNT_W-1 and never wrap.
REQ-026 clr with a simultaneous resolve: clr has priority; counters go to 0 and err_sticky goes to 0. Pending attempts are unaffected and continue to resolve.
REQ-027 Deasserting en: deasserting en[i] stops new launches only; in-flight attempts still resolve.
REQ-028 busy: busy[i] equals the OR of lane i's age vector after the current update.

Reset
REQ-029 When rst_n=0: all age vectors, pulses, counters, err_sticky and busy clear to 0 immediately.
REQ-030 Reset mid-operation discards all in-flight attempts without reporting any pass or fail.
REQ-031 Launch after reset: the first launch can occur at the first posedge after rst_n rises.

Structure
REQ-032 Package delay_chk_pkg holds the MAX_CHANNELS=16 and MAX_DELAY=16 limits and a popcount function.
REQ-033 Parameter legality is checked at elaboration; an illegal combination is a fatal error.
REQ-034 One sub-module, delay_chk_lane, implements a single lane; the top level generates CHANNELS instances of it.

Verification
REQ-035 Exact delay (MIN=MAX=2): a=1 at edge 0; b=0 at edge 2 -> fail_pulse in cycle 3, fail_cnt=1, err_sticky=1.
REQ-036 Overlap (MIN=MAX=2): a=1 at edges 0,1,2; b=1 at edges 2,4 only -> pass, fail, pass in cycles 3,4,5; pass_cnt=2, fail_cnt=1.
REQ-037 Window (MIN=1, MAX=3): a=1 at edges 0 and 1; b=1 only at edge 2 -> both attempts pass at edge 2; pass_cnt increases by 2; busy low from cycle 3.
REQ-038 Saturation (CNT_W=2): five consecutive failing attempts -> fail_cnt holds at 3.
REQ-039 Reset mid-flight: attempt launched at edge 0, rst_n pulsed low at edge 1 -> no pulses appear and all counters remain 0.
REQ-040 Lane isolation (CHANNELS=4): stimulus on lane 2 only -> lanes 0, 1 and 3 keep all outputs at 0.

Source files
------------

// File: rtl/delay_chk_pkg.sv
// Shared limits and helpers for the delayed-sequence checker.
// Imported by the lane and the top level.
package delay_chk_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int MAX_DELAY    = 16;
    localparam int PC_W         = 5;

    typedef logic [PC_W-1:0] pc_t;

    typedef struct packed {
        pc_t  n_pass;
        logic fail;
    } lane_res_t;

    function automatic pc_t popcount(input logic [MAX_DELAY-1:0] v);
        pc_t n;
        n = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            n = n + {{(PC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/delay_chk_lane.sv
// One checker lane: tracks pending a->b attempts by age.
// Resolves passes inside the window and fails at the last age.
module delay_chk_lane
    import delay_chk_pkg::*;
#(
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic             pass_pulse,
    output logic             fail_pulse,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic             busy
);

    logic [MAX_DLY-1:0]   vec_q;
    logic [MAX_DLY-1:0]   vec_d;
    logic [MAX_DLY:1]     age;
    logic [MAX_DLY:1]     win;
    logic [MAX_DLY:1]     hit;
    logic [MAX_DELAY-1:0] pc_in;
    lane_res_t            res;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] c,
        input pc_t              n
    );
        logic [CNT_W+PC_W:0] s;
        s = {{(PC_W+1){1'b0}}, c} + {{(CNT_W+1){1'b0}}, n};
        if (s > {{(PC_W+1){1'b0}}, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    // vec_q[j] is an attempt that will be j+1 edges old at the coming edge
    assign age = vec_q;

    always_comb begin
        win = '0;
        for (int k = 1; k <= MAX_DLY; k++) begin
            win[k] = (k >= MIN_DLY);
        end
    end

    always_comb begin
        hit   = b ? (age & win) : '0;
        pc_in = '0;
        pc_in[MAX_DLY-1:0] = hit;
        res.n_pass = popcount(pc_in);
        res.fail   = age[MAX_DLY] & ~b;
    end

    always_comb begin
        vec_d    = '0;
        vec_d[0] = a & en;
        for (int k = 1; k < MAX_DLY; k++) begin
            vec_d[k] = age[k] & ~hit[k];
        end
    end

    assign busy = |vec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q      <= '0;
            pass_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_sticky <= 1'b0;
        end else begin
            vec_q      <= vec_d;
            pass_pulse <= |hit;
            fail_pulse <= res.fail;
            if (clr) begin
                pass_cnt   <= '0;
                fail_cnt   <= '0;
                err_sticky <= 1'b0;
            end else begin
                pass_cnt   <= sat_add(pass_cnt, res.n_pass);
                fail_cnt   <= sat_add(fail_cnt, {{(PC_W-1){1'b0}}, res.fail});
                err_sticky <= err_sticky | res.fail;
            end
        end
    end

endmodule

// File: rtl/delay_seq_checker.sv
// Multi-lane delayed-sequence checker: a |-> ##[MIN:MAX] b per lane.
// Lanes are independent; counters and sticky flags are per lane.
module delay_seq_checker
    import delay_chk_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MIN_DLY  = 2,
    parameter int MAX_DLY  = 2,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       a,
    input  logic [CHANNELS-1:0]       b,
    input  logic                      clr,
    output logic [CHANNELS-1:0]       pass_pulse,
    output logic [CHANNELS-1:0]       fail_pulse,
    output logic [CHANNELS*CNT_W-1:0] pass_cnt,
    output logic [CHANNELS*CNT_W-1:0] fail_cnt,
    output logic [CHANNELS-1:0]       err_sticky,
    output logic [CHANNELS-1:0]       busy
);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS ||
        MIN_DLY < 1 || MIN_DLY > MAX_DLY ||
        MAX_DLY > MAX_DELAY || CNT_W < 1) begin : g_bad_param
        $fatal(1, "delay_seq_checker: illegal parameters");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        delay_chk_lane #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY),
            .CNT_W   (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en[i]),
            .a          (a[i]),
            .b          (b[i]),
            .clr        (clr),
            .pass_pulse (pass_pulse[i]),
            .fail_pulse (fail_pulse[i]),
            .pass_cnt   (pass_cnt[i*CNT_W +: CNT_W]),
            .fail_cnt   (fail_cnt[i*CNT_W +: CNT_W]),
            .err_sticky (err_sticky[i]),
            .busy       (busy[i])
        );
    end

endmodule
